// File: rtl/lcd_bus_responder.sv
// Character-LCD (HD44780-style) bus responder: synchronizes host bus strobes,
// decodes instructions/data into a 2x16 DDRAM model and emulates busy timing.
module lcd_bus_responder #(
  parameter int unsigned BUSY_CYC      = 2000,
  parameter int unsigned BUSY_LONG_CYC = 82000
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic [7:0] LCD_DATA,
  input  logic       LCD_RS,
  input  logic       LCD_RW,
  input  logic       LCD_EN,
  output logic [7:0] oRD_DATA,
  output logic       oRD_OE,
  input  logic [4:0] iCHAR_ADDR,
  output logic [7:0] oCHAR,
  output logic       oBUSY,
  output logic [6:0] oAC,
  output logic [2:0] oDISP,
  output logic [2:0] oFUNC,
  output logic       oID,
  output logic       oWR_STB,
  output logic       oERR
);

  typedef enum logic [1:0] {IDLE, EXEC, CLEARING, BUSY} state_t;

  localparam logic [16:0] SHORT_LOAD = 17'(BUSY_CYC - 1);
  localparam logic [16:0] LONG_LOAD  = 17'(BUSY_LONG_CYC - 1);

  state_t      state, stateNext;
  logic [1:0]  enSr, rsSr, rwSr;
  logic [7:0]  dataS1, dataS2;
  logic        enPrev;
  logic        rsRise, rwRise, ctrlBad;
  logic        enSync, rsSync, rwSync;
  logic        enRise, enFall, fallValid;
  logic        txRs;
  logic [7:0]  txData;
  logic [16:0] busyCnt;
  logic [4:0]  clrIdx;
  logic [7:0]  cells [32];
  logic [6:0]  ac;
  logic        id;
  logic        errNext;
  logic        isClear, isLong, addrErr;

  function automatic logic [4:0] cellIdx(input logic [6:0] a);
    return {a[6], a[3:0]};
  endfunction

  function automatic logic addrValid(input logic [6:0] a);
    return (a[6:4] == 3'b000) || (a[6:4] == 3'b100);
  endfunction

  // Two visible rows are not contiguous in AC space; wrap between them.
  function automatic logic [6:0] stepAc(input logic [6:0] a, input logic inc);
    logic [6:0] r;
    if (inc) begin
      if (a == 7'h0F)      r = 7'h40;
      else if (a == 7'h4F) r = 7'h00;
      else                 r = a + 7'd1;
    end else begin
      if (a == 7'h40)      r = 7'h0F;
      else if (a == 7'h00) r = 7'h4F;
      else                 r = a - 7'd1;
    end
    return r;
  endfunction

  assign enSync    = enSr[1];
  assign rsSync    = rsSr[1];
  assign rwSync    = rwSr[1];
  assign enRise    = enSync && !enPrev;
  assign enFall    = !enSync && enPrev;
  // A strobe counts only if RS/RW held the value seen at its rising edge.
  assign fallValid = enFall && !ctrlBad && (rsSync == rsRise) && (rwSync == rwRise);

  assign isClear = !txRs && (txData == 8'h01);
  assign isLong  = !txRs && (txData[7:2] == 6'd0) && (txData[1:0] != 2'd0);
  assign addrErr = !txRs && txData[7] && !addrValid(txData[6:0]);

  assign oBUSY   = (state != IDLE);
  assign oWR_STB = (state == EXEC) && !addrErr;
  assign oAC     = ac;
  assign oID     = id;
  assign oCHAR   = cells[iCHAR_ADDR];

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      enSr    <= '0;
      rsSr    <= '0;
      rwSr    <= '0;
      dataS1  <= '0;
      dataS2  <= '0;
      enPrev  <= 1'b0;
      rsRise  <= 1'b0;
      rwRise  <= 1'b0;
      ctrlBad <= 1'b0;
    end else begin
      enSr   <= {enSr[0], LCD_EN};
      rsSr   <= {rsSr[0], LCD_RS};
      rwSr   <= {rwSr[0], LCD_RW};
      dataS1 <= LCD_DATA;
      dataS2 <= dataS1;
      enPrev <= enSync;
      if (enRise) begin
        rsRise  <= rsSync;
        rwRise  <= rwSync;
        ctrlBad <= 1'b0;
      end else if (enSync && ((rsSync != rsRise) || (rwSync != rwRise))) begin
        ctrlBad <= 1'b1;
      end
    end
  end

  always_comb begin
    stateNext = state;
    errNext   = 1'b0;
    case (state)
      IDLE:     if (fallValid && !rwSync) stateNext = EXEC;
      EXEC:     stateNext = isClear ? CLEARING : BUSY;
      CLEARING: if (clrIdx == 5'd31) stateNext = BUSY;
      BUSY:     if (busyCnt == '0) stateNext = IDLE;
      default:  stateNext = IDLE;
    endcase
    if (fallValid && !rwSync && (state != IDLE)) errNext = 1'b1;
    if ((state == EXEC) && addrErr) errNext = 1'b1;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state    <= IDLE;
      txRs     <= 1'b0;
      txData   <= '0;
      busyCnt  <= '0;
      clrIdx   <= '0;
      ac       <= '0;
      id       <= 1'b1;
      oDISP    <= '0;
      oFUNC    <= '0;
      oERR     <= 1'b0;
      oRD_OE   <= 1'b0;
      oRD_DATA <= '0;
      for (int unsigned i = 0; i < 32; i++) cells[i] <= 8'h20;
    end else begin
      state  <= stateNext;
      oERR   <= errNext;
      oRD_OE <= rwSync && enSync;
      if (rwSync && enSync) oRD_DATA <= rsSync ? cells[cellIdx(ac)] : {oBUSY, ac};
      else                  oRD_DATA <= '0;

      case (state)
        IDLE: begin
          if (fallValid && !rwSync) begin
            txRs   <= rsSync;
            txData <= dataS2;
          end else if (fallValid && rwSync && rsSync) begin
            ac <= stepAc(ac, id);
          end
        end
        EXEC: begin
          clrIdx  <= '0;
          busyCnt <= isLong ? LONG_LOAD : SHORT_LOAD;
          if (txRs) begin
            cells[cellIdx(ac)] <= txData;
            ac <= stepAc(ac, id);
          end else begin
            casez (txData)
              8'b1???????: if (addrValid(txData[6:0])) ac <= txData[6:0];
              8'b001?????: oFUNC <= txData[4:2];
              8'b00001???: oDISP <= txData[2:0];
              8'b000001??: id <= txData[1];
              8'b0000001?: ac <= '0;
              8'b00000001: begin
                ac <= '0;
                id <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        CLEARING: begin
          cells[clrIdx] <= 8'h20;
          clrIdx <= clrIdx + 5'd1;
        end
        BUSY: if (busyCnt != '0) busyCnt <= busyCnt - 17'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Directed bench for lcd_bus_responder with shortened busy timing.
module tb_lcd_bus_responder;

  localparam int unsigned BCYC  = 150;
  localparam int unsigned BLONG = 300;

  logic       iCLK = 1'b0;
  logic       iRST_N = 1'b0;
  logic [7:0] LCD_DATA = '0;
  logic       LCD_RS = 1'b0, LCD_RW = 1'b0, LCD_EN = 1'b0;
  logic [7:0] oRD_DATA;
  logic       oRD_OE;
  logic [4:0] iCHAR_ADDR = '0;
  logic [7:0] oCHAR;
  logic       oBUSY;
  logic [6:0] oAC;
  logic [2:0] oDISP, oFUNC;
  logic       oID, oWR_STB, oERR;

  int vectors = 0;
  int miscompares = 0;
  int errCount = 0;
  int wrStbCount = 0;

  lcd_bus_responder #(.BUSY_CYC(BCYC), .BUSY_LONG_CYC(BLONG)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .LCD_DATA(LCD_DATA), .LCD_RS(LCD_RS),
    .LCD_RW(LCD_RW), .LCD_EN(LCD_EN), .oRD_DATA(oRD_DATA), .oRD_OE(oRD_OE),
    .iCHAR_ADDR(iCHAR_ADDR), .oCHAR(oCHAR), .oBUSY(oBUSY), .oAC(oAC),
    .oDISP(oDISP), .oFUNC(oFUNC), .oID(oID), .oWR_STB(oWR_STB), .oERR(oERR)
  );

  always #5 iCLK = ~iCLK;

  always @(negedge iCLK) begin
    if (oERR) errCount++;
    if (oWR_STB) wrStbCount++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge iCLK);
  endtask

  task automatic pulse(input logic rs, input logic rw, input logic [7:0] d);
    @(negedge iCLK);
    LCD_RS = rs; LCD_RW = rw; LCD_DATA = d; LCD_EN = 1'b1;
    tick(4);
    LCD_EN = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (oBUSY && n < 2000) begin
      @(negedge iCLK);
      n++;
    end
    if (oBUSY) begin
      vectors++; miscompares++;
      $display("FAIL wait_idle: oBUSY still 1 after %0d cycles, required 0", n);
    end
  endtask

  task automatic writeOp(input logic rs, input logic [7:0] d);
    pulse(rs, 1'b0, d);
    tick(4);
    waitIdle();
  endtask

  task automatic readOp(input logic rs, output logic [7:0] got, output logic oe);
    @(negedge iCLK);
    LCD_RS = rs; LCD_RW = 1'b1; LCD_EN = 1'b1;
    tick(4);
    got = oRD_DATA; oe = oRD_OE;
    LCD_EN = 1'b0;
    tick(4);
    LCD_RW = 1'b0;
  endtask

  task automatic test_reset();
    iRST_N = 1'b0;
    tick(3);
    vectors++;
    if (oBUSY !== 1'b0 || oAC !== 7'h00 || oID !== 1'b1 || oDISP !== 3'b000 || oFUNC !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_regs: busy=%b ac=%h id=%b disp=%b func=%b, required 0 00 1 000 000", oBUSY, oAC, oID, oDISP, oFUNC);
    end
    vectors++;
    if (oRD_OE !== 1'b0 || oRD_DATA !== 8'h00 || oWR_STB !== 1'b0 || oERR !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_io: oe=%b rd=%h stb=%b err=%b, required 0 00 0 0", oRD_OE, oRD_DATA, oWR_STB, oERR);
    end
    iCHAR_ADDR = 5'd17; #1;
    vectors++;
    if (oCHAR !== 8'h20) begin
      miscompares++;
      $display("FAIL reset_cell: got %h, required 20", oCHAR);
    end
    @(negedge iCLK);
    iRST_N = 1'b1;
    tick(2);
  endtask

  task automatic test_init_sequence();
    int stb0 = wrStbCount;
    logic [7:0] exp [3] = '{8'h4F, 8'h6C, 8'h61};
    writeOp(1'b0, 8'h38);
    writeOp(1'b0, 8'h0C);
    writeOp(1'b0, 8'h01);
    writeOp(1'b0, 8'h06);
    writeOp(1'b0, 8'h86);
    writeOp(1'b1, 8'h4F);
    writeOp(1'b1, 8'h6C);
    writeOp(1'b1, 8'h61);
    vectors++;
    if (oFUNC !== 3'b110 || oDISP !== 3'b100) begin
      miscompares++;
      $display("FAIL init_cfg: func=%b disp=%b, required 110 100", oFUNC, oDISP);
    end
    for (int i = 0; i < 3; i++) begin
      iCHAR_ADDR = 5'(6 + i); #1;
      vectors++;
      if (oCHAR !== exp[i]) begin
        miscompares++;
        $display("FAIL init_cell%0d: got %h, required %h", 6 + i, oCHAR, exp[i]);
      end
    end
    vectors++;
    if (oAC !== 7'h09) begin
      miscompares++;
      $display("FAIL init_ac: got %h, required 09", oAC);
    end
    vectors++;
    if (wrStbCount - stb0 !== 8) begin
      miscompares++;
      $display("FAIL init_wrstb: got %0d pulses, required 8", wrStbCount - stb0);
    end
  endtask

  task automatic test_data_read();
    logic [7:0] got;
    logic oe;
    readOp(1'b0, got, oe);
    vectors++;
    if (got !== 8'h09 || oe !== 1'b1) begin
      miscompares++;
      $display("FAIL instr_read: data=%h oe=%b, required 09 1", got, oe);
    end
    writeOp(1'b0, 8'h86);
    readOp(1'b1, got, oe);
    vectors++;
    if (got !== 8'h4F || oe !== 1'b1) begin
      miscompares++;
      $display("FAIL data_read: data=%h oe=%b, required 4f 1", got, oe);
    end
    vectors++;
    if (oAC !== 7'h07) begin
      miscompares++;
      $display("FAIL data_read_step: ac=%h, required 07", oAC);
    end
  endtask

  task automatic test_wrap();
    writeOp(1'b0, 8'h8F);
    writeOp(1'b1, 8'h41);
    writeOp(1'b1, 8'h42);
    iCHAR_ADDR = 5'd15; #1;
    vectors++;
    if (oCHAR !== 8'h41) begin
      miscompares++;
      $display("FAIL wrap_cell15: got %h, required 41", oCHAR);
    end
    iCHAR_ADDR = 5'd16; #1;
    vectors++;
    if (oCHAR !== 8'h42 || oAC !== 7'h41) begin
      miscompares++;
      $display("FAIL wrap_inc: cell16=%h ac=%h, required 42 41", oCHAR, oAC);
    end
    writeOp(1'b0, 8'h04);
    writeOp(1'b0, 8'hC0);
    writeOp(1'b1, 8'h43);
    iCHAR_ADDR = 5'd16; #1;
    vectors++;
    if (oCHAR !== 8'h43 || oAC !== 7'h0F || oID !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_dec: cell16=%h ac=%h id=%b, required 43 0f 0", oCHAR, oAC, oID);
    end
    writeOp(1'b0, 8'h80);
    writeOp(1'b1, 8'h44);
    iCHAR_ADDR = 5'd0; #1;
    vectors++;
    if (oCHAR !== 8'h44 || oAC !== 7'h4F) begin
      miscompares++;
      $display("FAIL wrap_dec0: cell0=%h ac=%h, required 44 4f", oCHAR, oAC);
    end
  endtask

  task automatic test_busy_reject();
    int err0 = errCount;
    logic [7:0] got;
    logic oe;
    pulse(1'b0, 1'b0, 8'h06);
    tick(96);
    pulse(1'b1, 1'b0, 8'h55);
    tick(4);
    vectors++;
    if (errCount - err0 !== 1) begin
      miscompares++;
      $display("FAIL busy_err: got %0d err cycles, required 1", errCount - err0);
    end
    iCHAR_ADDR = 5'd31; #1;
    vectors++;
    if (oAC !== 7'h4F || oCHAR !== 8'h20 || oID !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_state: ac=%h cell31=%h id=%b, required 4f 20 1", oAC, oCHAR, oID);
    end
    readOp(1'b0, got, oe);
    vectors++;
    if (got !== 8'hCF) begin
      miscompares++;
      $display("FAIL busy_read: got %h, required cf", got);
    end
    waitIdle();
  endtask

  task automatic test_clear();
    int n = 0;
    int cnt = 0;
    writeOp(1'b0, 8'h04);
    pulse(1'b0, 1'b0, 8'h01);
    while (!oBUSY && n < 10) begin
      tick(1);
      n++;
    end
    while (oBUSY && cnt < 1000) begin
      cnt++;
      tick(1);
    end
    vectors++;
    if (cnt !== 1 + 32 + BLONG) begin
      miscompares++;
      $display("FAIL clear_busy_len: got %0d cycles, required %0d", cnt, 1 + 32 + BLONG);
    end
    for (int i = 0; i < 32; i++) begin
      iCHAR_ADDR = 5'(i); #1;
      vectors++;
      if (oCHAR !== 8'h20) begin
        miscompares++;
        $display("FAIL clear_cell%0d: got %h, required 20", i, oCHAR);
      end
    end
    vectors++;
    if (oAC !== 7'h00 || oID !== 1'b1) begin
      miscompares++;
      $display("FAIL clear_ac_id: ac=%h id=%b, required 00 1", oAC, oID);
    end
  endtask

  task automatic test_bad_addr();
    int err0;
    logic [7:0] got;
    logic oe;
    writeOp(1'b0, 8'h85);
    err0 = errCount;
    pulse(1'b0, 1'b0, 8'hA0);
    tick(4);
    waitIdle();
    vectors++;
    if (errCount - err0 !== 1 || oAC !== 7'h05) begin
      miscompares++;
      $display("FAIL bad_addr: err=%0d ac=%h, required 1 05", errCount - err0, oAC);
    end
    readOp(1'b0, got, oe);
    vectors++;
    if (got !== 8'h05) begin
      miscompares++;
      $display("FAIL bad_addr_read: got %h, required 05", got);
    end
  endtask

  task automatic test_glitch();
    int stb0 = wrStbCount;
    int busySeen = 0;
    @(negedge iCLK);
    LCD_RS = 1'b0; LCD_RW = 1'b0; LCD_DATA = 8'h80; LCD_EN = 1'b1;
    tick(2);
    LCD_RS = 1'b1;
    tick(2);
    LCD_EN = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (oBUSY) busySeen++;
    end
    LCD_RS = 1'b0;
    vectors++;
    if (busySeen !== 0 || wrStbCount !== stb0 || oAC !== 7'h05) begin
      miscompares++;
      $display("FAIL glitch_ignore: busy=%0d stb=%0d ac=%h, required 0 0 05", busySeen, wrStbCount - stb0, oAC);
    end
  endtask

  task automatic test_reset_mid_clear();
    int stb0;
    writeOp(1'b0, 8'h38);
    writeOp(1'b0, 8'h0F);
    writeOp(1'b0, 8'hC4);
    writeOp(1'b1, 8'h5A);
    iCHAR_ADDR = 5'd20; #1;
    vectors++;
    if (oCHAR !== 8'h5A || oDISP !== 3'b111) begin
      miscompares++;
      $display("FAIL pre_reset: cell20=%h disp=%b, required 5a 111", oCHAR, oDISP);
    end
    pulse(1'b0, 1'b0, 8'h01);
    tick(8);
    #2 iRST_N = 1'b0;
    #1;
    vectors++;
    if (oBUSY !== 1'b0 || oAC !== 7'h00 || oID !== 1'b1 || oDISP !== 3'b000 || oFUNC !== 3'b000 || oCHAR !== 8'h20) begin
      miscompares++;
      $display("FAIL mid_reset: busy=%b ac=%h id=%b disp=%b func=%b cell20=%h, required 0 00 1 000 000 20", oBUSY, oAC, oID, oDISP, oFUNC, oCHAR);
    end
    vectors++;
    if (oRD_OE !== 1'b0 || oRD_DATA !== 8'h00 || oWR_STB !== 1'b0 || oERR !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_io: oe=%b rd=%h stb=%b err=%b, required 0 00 0 0", oRD_OE, oRD_DATA, oWR_STB, oERR);
    end
    @(negedge iCLK);
    iRST_N = 1'b1;
    tick(2);
    stb0 = wrStbCount;
    writeOp(1'b0, 8'h86);
    vectors++;
    if (oAC !== 7'h06 || wrStbCount - stb0 !== 1) begin
      miscompares++;
      $display("FAIL post_reset_write: ac=%h stb=%0d, required 06 1", oAC, wrStbCount - stb0);
    end
  endtask

  initial begin
    test_reset();
    test_init_sequence();
    test_data_read();
    test_wrap();
    test_busy_reject();
    test_clear();
    test_bad_addr();
    test_glitch();
    test_reset_mid_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lcd_bus_responder.md
LCD_BUS_RESPONDER -- requirements
Module: lcd_bus_responder

Interface
REQ-001 SHALL have parameter BUSY_CYC, default 2000: busy cycles after a short instruction or data write (40 us at 50 MHz).
REQ-002 SHALL have parameter BUSY_LONG_CYC, default 82000: busy cycles after clear display or return home (1.64 ms); counter 17 bits.
REQ-003 SHALL have iCLK  in  1  system clock; all logic on rising edge.
REQ-004 SHALL have iRST_N  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have LCD_DATA  in  8  character-LCD bus data from the host controller.
REQ-006 SHALL have LCD_RS, LCD_RW, LCD_EN  in  1 each  register select (0 = instruction, 1 = data), read/write (1 = read), enable strobe.
REQ-007 SHALL have oRD_DATA  out  8  read-cycle response; oRD_OE  out  1  high while LCD_RW=1 and LCD_EN=1 (synchronized).
REQ-008 SHALL have iCHAR_ADDR  in  5  checker port index: 0-15 = line 1, 16-31 = line 2; oCHAR  out  8  DDRAM content at that index, combinational.
REQ-009 SHALL have oBUSY  out  1;  oAC  out  7  address counter;  oDISP  out  3  {display on, cursor, blink};  oFUNC  out  3  {DL, N, F};  oID  out  1  increment/decrement.
REQ-010 SHALL have oWR_STB  out  1  one-cycle pulse per accepted write;  oERR  out  1  one-cycle pulse per rejected write.

Function
REQ-011 SHALL pass LCD_EN, LCD_RS, LCD_RW and LCD_DATA through a 2-flop synchronizer and detect the falling edge of synchronized EN; the transaction is latched on that edge.
REQ-012 SHALL sequence states IDLE -> EXEC (1 cycle) -> BUSY, or IDLE -> EXEC -> CLEARING (32 cycles) -> BUSY, then BUSY -> IDLE when the busy counter expires.
REQ-013 SHALL assert oBUSY in EXEC, CLEARING and BUSY; oBUSY rises in the cycle after the detected EN fall.
REQ-014 SHALL ignore a write (RW=0) whose EN fall occurs while oBUSY=1: no state change, oERR pulses.
REQ-015 SHALL decode instruction writes (RS=0) by highest set bit: 0x01 clear; 0x02-0x03 return home; 0x04-0x07 entry mode (ID=bit1); 0x08-0x0F display control; 0x10-0x1F cursor shift (accepted, no effect); 0x20-0x3F function set (DL, N, F = bits 4,3,2); 0x40-0x7F CGRAM address (accepted, no effect); 0x80-0xFF set DDRAM address.
REQ-016 SHALL, on clear: write 0x20 to all 32 cells one per cycle in CLEARING, set AC=0x00 and ID=1, then BUSY_LONG_CYC busy cycles.
REQ-017 SHALL, on return home: set AC=0x00 with DDRAM unchanged, then BUSY_LONG_CYC busy cycles.
REQ-018 SHALL, on set DDRAM address, load AC=data[6:0] only if it is in 0x00-0x0F or 0x40-0x4F; otherwise oERR pulses and AC is unchanged (still BUSY_CYC busy).
REQ-019 SHALL, on data write (RS=1), store the byte at the cell mapped from AC (0x00-0x0F -> 0-15, 0x40-0x4F -> 16-31), then step AC.
REQ-020 SHALL step AC by ID. ID=1: +1, with 0x0F -> 0x40 and 0x4F -> 0x00. ID=0: -1, with 0x40 -> 0x0F and 0x00 -> 0x4F.
REQ-021 SHALL, on instruction read (RS=0, RW=1), drive oRD_DATA={oBUSY, oAC}; reads are permitted while busy and have no side effect.
REQ-022 SHALL, on data read (RS=1, RW=1), drive the cell at AC; on that read's EN fall, step AC per REQ-020 if not busy.
REQ-023 SHALL pulse oWR_STB in the EXEC cycle of every accepted write.
REQ-024 SHALL ignore EN pulses whose RS/RW change while EN is high; data is sampled at the detected fall.

Reset
REQ-025 SHALL, while iRST_N=0 at any time, including mid-CLEARING or mid-BUSY, immediately force: state IDLE; all cells 0x20; AC=0x00; ID=1; oDISP=000; oFUNC=000; busy counter 0; oBUSY, oWR_STB, oERR, oRD_OE = 0; oRD_DATA=0x00.
REQ-026 SHALL resume in IDLE on the first clock after reset release, accepting a new transaction.

Verification
REQ-027 Write sequence 0x38, 0x0C, 0x01, 0x06, 0x86, then data 'O','l','a' -> oFUNC=110, oDISP=100, cells 6/7/8 = 0x4F/0x6C/0x61, oAC=0x09.
REQ-028 Write 0x8F then two data bytes 0x41, 0x42 with ID=1 -> cell 15=0x41, cell 16=0x42, oAC=0x41; repeat with ID=0 at 0xC0 -> wraps to 0x0F.
REQ-029 Write during BUSY (2nd EN fall 100 cycles after 0x06) -> oERR one-cycle pulse, oAC/cells unchanged; busy read returns bit7=1.
REQ-030 Clear after filling cells -> oBUSY for 1+32+BUSY_LONG_CYC cycles; all cells 0x20; AC=0x00; ID=1.
REQ-031 Set DDRAM 0x20 (invalid) -> oERR pulse, AC unchanged; read instruction -> oRD_DATA={0, AC}.
REQ-032 Assert iRST_N=0 mid-CLEARING -> all outputs at REQ-025 values in the same cycle; first transaction after release is accepted.
